compare_timer: RTL and testbench

COMPARE_TIMER -- requirements
Module: compare_timer

---
 rtl/compare_timer.sv | 106 ++++++++++
 tb/tb_compare_timer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/compare_timer.sv
// compare_timer: WIDTH-bit up-counter with shadowed compare and period registers.
// Counts 0..period, then wraps (continuous) or returns to IDLE (oneshot).
// match/wrap are equality decodes of count against the active registers.
// Optional PWM output enabled by defining the macro COMPARE_TIMER_PWM_EN;
// without it pwm is tied low and no magnitude comparator is built.
module compare_timer #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             oneshot,
  input  logic             wr_en,
  input  logic             wr_sel,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             match,
  output logic             wrap,
  output logic             pwm
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  logic             mode;
  logic [WIDTH-1:0] cmp_sh;
  logic [WIDTH-1:0] per_sh;
  logic [WIDTH-1:0] cmp_act;
  logic [WIDTH-1:0] per_act;

  logic [WIDTH-1:0] cmp_diff;
  logic [WIDTH-1:0] per_diff;
  logic             cmp_eq;
  logic             per_eq;

  // Bitwise equality: XOR each bit, then NOR-reduce the difference vector.
  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_eq
      assign cmp_diff[i] = count[i] ^ cmp_act[i];
      assign per_diff[i] = count[i] ^ per_act[i];
    end
  endgenerate

  assign cmp_eq = ~|cmp_diff;
  assign per_eq = ~|per_diff;

  assign busy  = (state == RUN);
  assign match = busy & cmp_eq;
  assign wrap  = busy & per_eq;

`ifdef COMPARE_TIMER_PWM_EN
  assign pwm = busy & (count < cmp_act);
`else
  assign pwm = 1'b0;
`endif

  // Shadow-register writes; allowed in any state, picked up on the next reload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp_sh <= '0;
      per_sh <= '1;
    end else if (wr_en) begin
      if (wr_sel) per_sh <= wr_data;
      else        cmp_sh <= wr_data;
    end
  end

  // Control FSM and counter: stop beats start, start beats the wrap action.
  // Reloads read the shadows before any same-edge write lands in them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      count   <= '0;
      mode    <= 1'b0;
      cmp_act <= '0;
      per_act <= '1;
    end else if (stop) begin
      if (state == RUN) state <= IDLE;
    end else if (start) begin
      state   <= RUN;
      count   <= '0;
      mode    <= oneshot;
      cmp_act <= cmp_sh;
      per_act <= per_sh;
    end else if (state == RUN) begin
      if (per_eq) begin
        count <= '0;
        if (mode) begin
          state <= IDLE;
        end else begin
          cmp_act <= cmp_sh;
          per_act <= per_sh;
        end
      end else begin
        count <= count + WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_compare_timer.sv
// tb_compare_timer: table-driven directed vectors for compare_timer (WIDTH=6),
// followed by hand-written sequences for period 0, compare beyond period,
// PWM duty and asynchronous reset mid-run.
module tb_compare_timer;

  localparam int W = 6;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         stop;
  logic         oneshot;
  logic         wr_en;
  logic         wr_sel;
  logic [W-1:0] wr_data;
  logic [W-1:0] count;
  logic         busy;
  logic         match;
  logic         wrap;
  logic         pwm;

  int pass_cnt  = 0;
  int total_cnt = 0;

  compare_timer #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .stop    (stop),
    .oneshot (oneshot),
    .wr_en   (wr_en),
    .wr_sel  (wr_sel),
    .wr_data (wr_data),
    .count   (count),
    .busy    (busy),
    .match   (match),
    .wrap    (wrap),
    .pwm     (pwm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         st;
    logic         sp;
    logic         os;
    logic         we;
    logic         ws;
    logic [W-1:0] wd;
    logic [W-1:0] c;
    logic         b;
    logic         m;
    logic         w;
    logic         p;
  } vec_t;

  vec_t tbl[$];

  // Expected pwm: the enabled-build value, or constant 0 when the feature is absent.
  function automatic logic pwm_req(input logic v);
`ifdef COMPARE_TIMER_PWM_EN
    return v;
`else
    return 1'b0;
`endif
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic check_all(input string tag, input int c, input logic b,
                           input logic m, input logic w, input logic p);
    check({tag, ".count"}, int'(count), c);
    check({tag, ".busy"},  int'(busy),  int'(b));
    check({tag, ".match"}, int'(match), int'(m));
    check({tag, ".wrap"},  int'(wrap),  int'(w));
    check({tag, ".pwm"},   int'(pwm),   int'(pwm_req(p)));
  endtask

  task automatic add(input logic st, input logic sp, input logic os,
                     input logic we, input logic ws, input int wd,
                     input int c, input logic b, input logic m,
                     input logic w, input logic p);
    vec_t v;
    v.st = st; v.sp = sp; v.os = os; v.we = we; v.ws = ws;
    v.wd = W'(wd); v.c = W'(c); v.b = b; v.m = m; v.w = w; v.p = p;
    tbl.push_back(v);
  endtask

  // Drive one cycle of inputs at negedge, sample 1 time unit after the next posedge.
  task automatic cycle(input logic st, input logic sp, input logic os,
                       input logic we, input logic ws, input int wd);
    @(negedge clk);
    start = st; stop = sp; oneshot = os;
    wr_en = we; wr_sel = ws; wr_data = W'(wd);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; oneshot = 1'b0;
    wr_en = 1'b0; wr_sel = 1'b0; wr_data = '0;

    //  st sp os we ws wd   cnt b m w p
    add(0, 0, 0, 1, 0, 3,   0, 0, 0, 0, 0);  // compare shadow = 3
    add(0, 0, 0, 1, 1, 5,   0, 0, 0, 0, 0);  // period shadow = 5
    add(1, 0, 0, 0, 0, 0,   0, 1, 0, 0, 1);  // continuous start
    add(0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0,   2, 1, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0,   3, 1, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0,   4, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0,   5, 1, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 1);  // wrapped, still running
    add(0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 1);
    add(0, 0, 0, 1, 1, 2,   2, 1, 0, 0, 1);  // period shadow = 2 at count 1
    add(0, 0, 0, 0, 0, 0,   3, 1, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0,   4, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0,   5, 1, 0, 1, 0);  // current pass still ends at 5
    add(0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0,   2, 1, 0, 1, 1);  // new period 2
    add(0, 0, 0, 1, 1, 5,   0, 1, 0, 0, 1);  // write on the wrap edge
    add(0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0,   2, 1, 0, 1, 1);  // still period 2 this pass
    add(0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0,   2, 1, 0, 0, 1);  // period 5 in force now
    add(0, 0, 0, 0, 0, 0,   3, 1, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0,   4, 1, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0,   4, 0, 0, 0, 0);  // start+stop: stop wins, hold 4
    add(0, 1, 0, 0, 0, 0,   4, 0, 0, 0, 0);  // stop in IDLE: no effect
    add(1, 0, 1, 0, 0, 0,   0, 1, 0, 0, 1);  // oneshot start
    add(0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0,   2, 1, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0,   3, 1, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0,   4, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0,   5, 1, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);  // oneshot done -> IDLE
    add(0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);  // stays idle
    add(1, 0, 0, 0, 0, 0,   0, 1, 0, 0, 1);  // continuous start
    add(0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0,   2, 1, 0, 0, 1);
    add(1, 0, 0, 0, 0, 0,   0, 1, 0, 0, 1);  // restart mid-run

    // Reset state
    #12;
    check_all("reset", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      cycle(tbl[i].st, tbl[i].sp, tbl[i].os, tbl[i].we, tbl[i].ws, int'(tbl[i].wd));
      check_all($sformatf("vec%0d", i), int'(tbl[i].c), tbl[i].b, tbl[i].m, tbl[i].w, tbl[i].p);
    end

    // Period 0, compare 0: match and wrap every RUN cycle
    cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 0, 0);
    cycle(0, 0, 0, 1, 1, 0);
    cycle(1, 0, 0, 0, 0, 0);
    check_all("p0_start", 0, 1, 1, 1, 0);
    for (int k = 0; k < 3; k++) begin
      cycle(0, 0, 0, 0, 0, 0);
      check_all($sformatf("p0_run%0d", k), 0, 1, 1, 1, 0);
    end

    // Compare 9 beyond period 5: match never asserts
    cycle(0, 0, 0, 1, 0, 9);
    cycle(0, 0, 0, 1, 1, 5);
    cycle(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 12; k++) begin
      if (k != 0) cycle(0, 0, 0, 0, 0, 0);
      check_all($sformatf("c9_%0d", k), k % 6, 1, 0, (k % 6) == 5, 1);
    end

    // PWM duty with compare 2, period 5, then asynchronous reset mid-run
    cycle(0, 0, 0, 1, 0, 2);
    cycle(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 9; k++) begin
      if (k != 0) cycle(0, 0, 0, 0, 0, 0);
      check_all($sformatf("pwm_%0d", k), k % 6, 1, (k % 6) == 2, (k % 6) == 5, (k % 6) < 2);
    end
    #2;
    rst_n = 1'b0;
    #1;
    check_all("async_rst", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle(0, 0, 0, 0, 0, 0);
      check_all($sformatf("post_rst%0d", k), 0, 0, 0, 0, 0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
